// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the RAM data-port arbiter: transfer sizes,
// port indices and the byte-lane mask computation.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Lane mask for a transfer; callers truncate to their lane count, which is
    // what drops the upper lane of a half-word at offset 3.
    function automatic logic [15:0] byte_mask(input logic [1:0] size,
                                              input logic [1:0] addr_lo,
                                              input int unsigned nb = 4);
        logic [15:0] m;
        case (size)
            SZ_BYTE: m = 16'h0001 << addr_lo;
            SZ_HALF: m = 16'h0003 << addr_lo;
            default: m = (nb >= 16) ? 16'hFFFF : ((16'h0001 << nb) - 16'h0001);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic with an optional round-robin tie break; last_grant
// remembers the most recently accepted port.
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic last_grant_reg;

    // On a tie, port 1 wins only when round-robin is on and port 0 went last.
    assign grant1 = valid1 & (~valid0 | ((ROUND_ROBIN != 0) & (last_grant_reg == PORT0)));
    assign grant0 = valid0 & ~grant1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= PORT1;
        end else if (grant0 | grant1) begin
            last_grant_reg <= grant1 ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/dbus_ram_arbiter.sv
// Shares the RAM data port between the dBus (port 0) and a second master
// (port 1): grant, address/byte-enable conversion and read-response routing.
module dbus_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WL          = 32,
    parameter int RAM_ADDR_WL = 13,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   p0_cmd_valid,
    output logic                   p0_cmd_ready,
    input  logic                   p0_cmd_wr,
    input  logic [WL-1:0]          p0_cmd_addr,
    input  logic [WL-1:0]          p0_cmd_data,
    input  logic [1:0]             p0_cmd_size,
    output logic                   p0_rsp_valid,
    output logic [WL-1:0]          p0_rsp_data,
    output logic                   p0_rsp_error,
    input  logic                   p1_cmd_valid,
    output logic                   p1_cmd_ready,
    input  logic                   p1_cmd_wr,
    input  logic [WL-1:0]          p1_cmd_addr,
    input  logic [WL-1:0]          p1_cmd_data,
    input  logic [1:0]             p1_cmd_size,
    output logic                   p1_rsp_valid,
    output logic [WL-1:0]          p1_rsp_data,
    output logic                   p1_rsp_error,
    output logic [WL/8-1:0]        ram_we,
    output logic [RAM_ADDR_WL-1:0] ram_addr,
    output logic [WL-1:0]          ram_din,
    input  logic [WL-1:0]          ram_dout
);

    localparam int NB = WL / 8;
    typedef logic [NB-1:0] mask_t;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel;
    logic          sel_wr;
    logic [WL-1:0] sel_addr;
    logic [WL-1:0] sel_data;
    logic [1:0]    sel_size;
    logic          out_of_range;
    mask_t         mask;

    logic          rsp_pending_reg;
    logic          rsp_owner_reg;
    logic          rsp_err_reg;
    logic [1:0]    rsp_valid_vec;
    logic [1:0]    rsp_error_vec;
    logic [WL-1:0] rsp_data_arr [2];

    rr_arbiter2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .valid0 (p0_cmd_valid),
        .valid1 (p1_cmd_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Nothing may be accepted while reset is held, even with valid requests.
    assign p0_cmd_ready = grant0 & resetn;
    assign p1_cmd_ready = grant1 & resetn;
    assign accept       = p0_cmd_ready | p1_cmd_ready;
    assign sel          = grant1 ? PORT1 : PORT0;

    always_comb begin
        sel_wr   = p0_cmd_wr;
        sel_addr = p0_cmd_addr;
        sel_data = p0_cmd_data;
        sel_size = p0_cmd_size;
        if (sel == PORT1) begin
            sel_wr   = p1_cmd_wr;
            sel_addr = p1_cmd_addr;
            sel_data = p1_cmd_data;
            sel_size = p1_cmd_size;
        end
    end

    assign out_of_range = (sel_addr >> (RAM_ADDR_WL + 2)) != '0;
    assign mask         = mask_t'(byte_mask(sel_size, sel_addr[1:0], NB));

    assign ram_addr = sel_addr[RAM_ADDR_WL+1:2];
    assign ram_din  = sel_data;
    assign ram_we   = (accept && sel_wr && !out_of_range) ? mask : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_pending_reg <= 1'b0;
            rsp_owner_reg   <= PORT0;
            rsp_err_reg     <= 1'b0;
        end else begin
            rsp_pending_reg <= accept & ~sel_wr;
            rsp_owner_reg   <= sel;
            rsp_err_reg     <= out_of_range;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid_vec[gi] = rsp_pending_reg && (rsp_owner_reg == 1'(gi));
        assign rsp_error_vec[gi] = rsp_valid_vec[gi] & rsp_err_reg;
        assign rsp_data_arr[gi]  = (rsp_valid_vec[gi] && !rsp_err_reg) ? ram_dout : '0;
    end

    assign p0_rsp_valid = rsp_valid_vec[0];
    assign p0_rsp_error = rsp_error_vec[0];
    assign p0_rsp_data  = rsp_data_arr[0];
    assign p1_rsp_valid = rsp_valid_vec[1];
    assign p1_rsp_error = rsp_error_vec[1];
    assign p1_rsp_data  = rsp_data_arr[1];

endmodule

// File: tb/tb_dbus_ram_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized two-port run
// compared against a byte-level memory and grant model.
module tb_dbus_ram_arbiter;

    logic        clk;
    logic        resetn;
    logic        ram_init;

    logic        p0_cmd_valid, p0_cmd_ready, p0_cmd_wr;
    logic [31:0] p0_cmd_addr, p0_cmd_data;
    logic [1:0]  p0_cmd_size;
    logic        p0_rsp_valid, p0_rsp_error;
    logic [31:0] p0_rsp_data;
    logic        p1_cmd_valid, p1_cmd_ready, p1_cmd_wr;
    logic [31:0] p1_cmd_addr, p1_cmd_data;
    logic [1:0]  p1_cmd_size;
    logic        p1_rsp_valid, p1_rsp_error;
    logic [31:0] p1_rsp_data;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    // fixed-priority instance
    logic        q0_cmd_valid, f0_cmd_ready, f0_rsp_valid, f0_rsp_error;
    logic        q1_cmd_valid, f1_cmd_ready, f1_rsp_valid, f1_rsp_error;
    logic [31:0] f0_rsp_data, f1_rsp_data;
    logic [3:0]  f_ram_we;
    logic [12:0] f_ram_addr;
    logic [31:0] f_ram_din;
    logic [31:0] f_ram_dout;

    logic [31:0] tb_ram [0:8191];

    int checks   = 0;
    int failures = 0;

    dbus_ram_arbiter #(.WL(32), .RAM_ADDR_WL(13), .ROUND_ROBIN(1)) dut (
        .clk(clk), .resetn(resetn),
        .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_wr(p0_cmd_wr),
        .p0_cmd_addr(p0_cmd_addr), .p0_cmd_data(p0_cmd_data), .p0_cmd_size(p0_cmd_size),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data), .p0_rsp_error(p0_rsp_error),
        .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_wr(p1_cmd_wr),
        .p1_cmd_addr(p1_cmd_addr), .p1_cmd_data(p1_cmd_data), .p1_cmd_size(p1_cmd_size),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data), .p1_rsp_error(p1_rsp_error),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    dbus_ram_arbiter #(.WL(32), .RAM_ADDR_WL(13), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .resetn(resetn),
        .p0_cmd_valid(q0_cmd_valid), .p0_cmd_ready(f0_cmd_ready), .p0_cmd_wr(1'b0),
        .p0_cmd_addr(32'h20), .p0_cmd_data(32'h0), .p0_cmd_size(2'd2),
        .p0_rsp_valid(f0_rsp_valid), .p0_rsp_data(f0_rsp_data), .p0_rsp_error(f0_rsp_error),
        .p1_cmd_valid(q1_cmd_valid), .p1_cmd_ready(f1_cmd_ready), .p1_cmd_wr(1'b0),
        .p1_cmd_addr(32'h24), .p1_cmd_data(32'h0), .p1_cmd_size(2'd2),
        .p1_rsp_valid(f1_rsp_valid), .p1_rsp_data(f1_rsp_data), .p1_rsp_error(f1_rsp_error),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_din(f_ram_din), .ram_dout(f_ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one-cycle registered read and byte write enables
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 8192; i++) tb_ram[i] <= 32'h0;
            tb_ram[0] <= 32'hC3C3_C3C3;
            tb_ram[8] <= 32'hA0A0_A0A0;
            tb_ram[9] <= 32'hB1B1_B1B1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) tb_ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
        ram_dout <= tb_ram[ram_addr];
    end

    task automatic idle();
        p0_cmd_valid = 0; p0_cmd_wr = 0; p0_cmd_addr = 0; p0_cmd_data = 0; p0_cmd_size = 0;
        p1_cmd_valid = 0; p1_cmd_wr = 0; p1_cmd_addr = 0; p1_cmd_data = 0; p1_cmd_size = 0;
        q0_cmd_valid = 0; q1_cmd_valid = 0;
    endtask

    task automatic test_reset();
        resetn = 0; ram_init = 1; f_ram_dout = 32'h5A5A_5A5A;
        idle();
        @(negedge clk); @(negedge clk);
        p0_cmd_valid = 1; p0_cmd_wr = 1; p0_cmd_addr = 32'h10; p0_cmd_size = 2; p0_cmd_data = 32'hFFFF_FFFF;
        p1_cmd_valid = 1; q0_cmd_valid = 1; q1_cmd_valid = 1;
        #1;
        checks++;
        if ({p0_cmd_ready, p1_cmd_ready, f0_cmd_ready, f1_cmd_ready} !== 4'b0) begin
            failures++; $display("FAIL reset_ready got=%b want=0000",
                {p0_cmd_ready, p1_cmd_ready, f0_cmd_ready, f1_cmd_ready});
        end
        checks++;
        if (ram_we !== 4'h0) begin
            failures++; $display("FAIL reset_we got=%h want=0", ram_we);
        end
        checks++;
        if ({p0_rsp_valid, p0_rsp_error, p1_rsp_valid, p1_rsp_error, p0_rsp_data, p1_rsp_data} !== 68'h0) begin
            failures++; $display("FAIL reset_rsp v0=%b e0=%b d0=%h v1=%b e1=%b d1=%h want all 0",
                p0_rsp_valid, p0_rsp_error, p0_rsp_data, p1_rsp_valid, p1_rsp_error, p1_rsp_data);
        end
        idle();
        @(negedge clk);
        ram_init = 0; resetn = 1;
        $display("reset: released");
    endtask

    task automatic test_contention();
        logic [31:0] word_for [2];
        int owner;
        word_for[0] = 32'hA0A0_A0A0;
        word_for[1] = 32'hB1B1_B1B1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i < 6) begin
                p0_cmd_valid = 1; p0_cmd_wr = 0; p0_cmd_addr = 32'h20; p0_cmd_size = 2;
                p1_cmd_valid = 1; p1_cmd_wr = 0; p1_cmd_addr = 32'h24; p1_cmd_size = 2;
                q0_cmd_valid = 1; q1_cmd_valid = 1;
            end else idle();
            #1;
            if (i < 6) begin
                checks++;
                if ({p0_cmd_ready, p1_cmd_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL rr_grant cyc=%0d got=%b%b want_port=%0d",
                        i, p0_cmd_ready, p1_cmd_ready, i % 2);
                end
                checks++;
                if ({f0_cmd_ready, f1_cmd_ready} !== 2'b10) begin
                    failures++; $display("FAIL fixed_grant cyc=%0d got=%b%b want=10", i, f0_cmd_ready, f1_cmd_ready);
                end
            end
            if (i >= 1) begin
                owner = (i - 1) % 2;
                checks++;
                if ({p0_rsp_valid, p1_rsp_valid} !== ((owner == 0) ? 2'b10 : 2'b01) ||
                    (owner == 0 && (p0_rsp_data !== word_for[0] || p1_rsp_data !== 32'h0)) ||
                    (owner == 1 && (p1_rsp_data !== word_for[1] || p0_rsp_data !== 32'h0))) begin
                    failures++; $display("FAIL rr_rsp cyc=%0d v=%b%b d0=%h d1=%h want owner=%0d data=%h",
                        i, p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data, owner, word_for[owner]);
                end
                checks++;
                if ({f0_rsp_valid, f1_rsp_valid} !== 2'b10 || f0_rsp_data !== 32'h5A5A_5A5A) begin
                    failures++; $display("FAIL fixed_rsp cyc=%0d v=%b%b d0=%h want 10 5a5a5a5a",
                        i, f0_rsp_valid, f1_rsp_valid, f0_rsp_data);
                end
            end
            $display("contention: cyc=%0d ready=%b%b fixed_ready=%b%b", i,
                p0_cmd_ready, p1_cmd_ready, f0_cmd_ready, f1_cmd_ready);
        end
    endtask

    task automatic test_word_rw();
        @(negedge clk);
        p0_cmd_valid = 1; p0_cmd_wr = 1; p0_cmd_addr = 32'h10; p0_cmd_size = 2; p0_cmd_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ram_we !== 4'hF || ram_addr !== 13'd4 || p0_cmd_ready !== 1'b1) begin
            failures++; $display("FAIL word_write we=%h addr=%0d rdy=%b want f 4 1", ram_we, ram_addr, p0_cmd_ready);
        end
        @(negedge clk);
        p0_cmd_wr = 0;
        #1;
        checks++;
        if (ram_we !== 4'h0 || ram_addr !== 13'd4) begin
            failures++; $display("FAIL word_read_cmd we=%h addr=%0d want 0 4", ram_we, ram_addr);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 32'hDEAD_BEEF || p0_rsp_error !== 1'b0 || p1_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL word_read_rsp v=%b d=%h e=%b v1=%b want 1 deadbeef 0 0",
                p0_rsp_valid, p0_rsp_data, p0_rsp_error, p1_rsp_valid);
        end
        $display("word_rw: rsp=%h", p0_rsp_data);
    endtask

    task automatic test_byte_mask();
        logic [1:0]  sz   [6];
        logic [31:0] ad   [6];
        logic [31:0] dat  [6];
        logic [3:0]  we_x [6];
        sz[0] = 3; ad[0] = 32'h10; dat[0] = 32'h1234_5678; we_x[0] = 4'b1111;
        sz[1] = 0; ad[1] = 32'h13; dat[1] = 32'hAA00_0000; we_x[1] = 4'b1000;
        sz[2] = 1; ad[2] = 32'h12; dat[2] = 32'h5566_0000; we_x[2] = 4'b1100;
        sz[3] = 1; ad[3] = 32'h13; dat[3] = 32'h7700_0000; we_x[3] = 4'b1000;
        sz[4] = 0; ad[4] = 32'h10; dat[4] = 32'h0000_0011; we_x[4] = 4'b0001;
        sz[5] = 1; ad[5] = 32'h10; dat[5] = 32'h0000_2233; we_x[5] = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p0_cmd_valid = 1; p0_cmd_wr = 1; p0_cmd_size = sz[i]; p0_cmd_addr = ad[i]; p0_cmd_data = dat[i];
            #1;
            checks++;
            if (ram_we !== we_x[i] || ram_addr !== 13'd4) begin
                failures++; $display("FAIL byte_mask idx=%0d we=%b addr=%0d want %b 4", i, ram_we, ram_addr, we_x[i]);
            end
            $display("byte_mask: size=%0d addr=%h we=%b", sz[i], ad[i], ram_we);
        end
        @(negedge clk);
        p0_cmd_wr = 0; p0_cmd_size = 2; p0_cmd_addr = 32'h10;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 32'h7766_2233) begin
            failures++; $display("FAIL byte_merge v=%b d=%h want 1 77662233", p0_rsp_valid, p0_rsp_data);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        p1_cmd_valid = 1; p1_cmd_wr = 0; p1_cmd_addr = 32'h0008_0000; p1_cmd_size = 2;
        #1;
        checks++;
        if (p1_cmd_ready !== 1'b1 || ram_we !== 4'h0) begin
            failures++; $display("FAIL oor_read_cmd rdy=%b we=%h want 1 0", p1_cmd_ready, ram_we);
        end
        @(negedge clk);
        p1_cmd_wr = 1; p1_cmd_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (p1_rsp_valid !== 1'b1 || p1_rsp_error !== 1'b1 || p1_rsp_data !== 32'h0 || p0_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL oor_rsp v=%b e=%b d=%h v0=%b want 1 1 0 0",
                p1_rsp_valid, p1_rsp_error, p1_rsp_data, p0_rsp_valid);
        end
        checks++;
        if (ram_we !== 4'h0 || p1_cmd_ready !== 1'b1) begin
            failures++; $display("FAIL oor_write we=%h rdy=%b want 0 1", ram_we, p1_cmd_ready);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (p1_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL oor_write_no_rsp v=%b want 0", p1_rsp_valid);
        end
        $display("out_of_range: checked read and write at 00080000");
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        p0_cmd_valid = 1; p0_cmd_wr = 0; p0_cmd_addr = 32'h20; p0_cmd_size = 2;
        @(posedge clk);
        #1 idle();
        #1 resetn = 0;
        @(negedge clk);
        resetn = 1;
        #1;
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_error} !== 3'b0 || p0_rsp_data !== 32'h0) begin
            failures++; $display("FAIL inflight_drop v=%b%b e=%b d=%h want 0", p0_rsp_valid, p1_rsp_valid, p0_rsp_error, p0_rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid} !== 2'b0) begin
            failures++; $display("FAIL inflight_late v=%b%b want 00", p0_rsp_valid, p1_rsp_valid);
        end
        p0_cmd_valid = 1; p0_cmd_wr = 0; p0_cmd_addr = 32'h20; p0_cmd_size = 2;
        p1_cmd_valid = 1; p1_cmd_wr = 0; p1_cmd_addr = 32'h24; p1_cmd_size = 2;
        #1;
        checks++;
        if ({p0_cmd_ready, p1_cmd_ready} !== 2'b10) begin
            failures++; $display("FAIL first_tie got=%b%b want 10", p0_cmd_ready, p1_cmd_ready);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 32'hA0A0_A0A0) begin
            failures++; $display("FAIL first_tie_rsp v=%b d=%h want 1 a0a0a0a0", p0_rsp_valid, p0_rsp_data);
        end
        $display("reset_inflight: response dropped, first tie to port 0");
    endtask

    task automatic test_random();
        logic        cv [2];
        logic        cw [2];
        logic [31:0] ca [2];
        logic [31:0] cd [2];
        logic [1:0]  cs [2];
        logic [7:0]  ref_bytes [0:255];
        int          last, win, len, lo;
        logic        ep_v, ep_e, inr;
        int          ep_o;
        logic [31:0] ep_d, word;
        logic [3:0]  exp_we;
        logic [33:0] got_r, exp_r;

        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
        cv[0] = 0; cv[1] = 0;
        ep_v = 0; ep_e = 0; ep_o = 0; ep_d = 0;
        @(negedge clk);
        idle(); resetn = 0;
        @(negedge clk);
        resetn = 1;
        last = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!cv[p] && $urandom_range(0, 9) < 7) begin
                    cv[p] = 1;
                    cw[p] = $urandom_range(0, 1) == 1;
                    cs[p] = 2'($urandom_range(0, 3));
                    cd[p] = $urandom;
                    ca[p] = 32'h40 + $urandom_range(0, 63);
                    if ($urandom_range(0, 7) == 0) ca[p] = ca[p] | (32'h1 << $urandom_range(15, 31));
                end
            end
            p0_cmd_valid = cv[0]; p0_cmd_wr = cw[0]; p0_cmd_addr = ca[0]; p0_cmd_data = cd[0]; p0_cmd_size = cs[0];
            p1_cmd_valid = cv[1]; p1_cmd_wr = cw[1]; p1_cmd_addr = ca[1]; p1_cmd_data = cd[1]; p1_cmd_size = cs[1];

            win = -1;
            if (cv[0] && cv[1]) win = (last == 0) ? 1 : 0;
            else if (cv[0]) win = 0;
            else if (cv[1]) win = 1;

            exp_we = 4'h0;
            inr = 1'b0;
            if (win >= 0) begin
                inr = (ca[win][31:15] == 17'h0);
                len = (cs[win] == 0) ? 1 : (cs[win] == 1) ? 2 : 4;
                lo  = (cs[win] >= 2) ? 0 : int'(ca[win][1:0]);
                if (cw[win] && inr)
                    for (int l = 0; l < 4; l++) exp_we[l] = (l >= lo) && (l < lo + len);
            end
            #1;
            checks++;
            if (p0_cmd_ready !== (win == 0) || p1_cmd_ready !== (win == 1)) begin
                failures++; $display("FAIL rand_grant n=%0d got=%b%b want_port=%0d", n, p0_cmd_ready, p1_cmd_ready, win);
            end
            checks++;
            if (ram_we !== exp_we) begin
                failures++; $display("FAIL rand_we n=%0d got=%b want=%b", n, ram_we, exp_we);
            end
            if (win >= 0) begin
                checks++;
                if (ram_addr !== ca[win][14:2]) begin
                    failures++; $display("FAIL rand_addr n=%0d got=%h want=%h", n, ram_addr, ca[win][14:2]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                got_r = (p == 0) ? {p0_rsp_valid, p0_rsp_error, p0_rsp_data} : {p1_rsp_valid, p1_rsp_error, p1_rsp_data};
                exp_r = (ep_v && ep_o == p) ? {1'b1, ep_e, ep_d} : 34'h0;
                checks++;
                if (got_r !== exp_r) begin
                    failures++; $display("FAIL rand_rsp n=%0d port=%0d got=%h want=%h", n, p, got_r, exp_r);
                end
            end
            $display("random: n=%0d win=%0d we=%b rsp=%b%b", n, win, ram_we, p0_rsp_valid, p1_rsp_valid);

            ep_v = 1'b0;
            if (win >= 0) begin
                word = {ref_bytes[{ca[win][7:2], 2'd3}], ref_bytes[{ca[win][7:2], 2'd2}],
                        ref_bytes[{ca[win][7:2], 2'd1}], ref_bytes[{ca[win][7:2], 2'd0}]};
                if (!cw[win]) begin
                    ep_v = 1'b1; ep_o = win; ep_e = !inr; ep_d = inr ? word : 32'h0;
                end else begin
                    for (int l = 0; l < 4; l++)
                        if (exp_we[l]) ref_bytes[{ca[win][7:2], 2'(l)}] = cd[win][8*l +: 8];
                end
                last = win;
                cv[win] = 0;
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({p0_rsp_valid, p0_rsp_error, p0_rsp_data} !== ((ep_v && ep_o == 0) ? {1'b1, ep_e, ep_d} : 34'h0) ||
            {p1_rsp_valid, p1_rsp_error, p1_rsp_data} !== ((ep_v && ep_o == 1) ? {1'b1, ep_e, ep_d} : 34'h0)) begin
            failures++; $display("FAIL rand_tail v=%b%b d0=%h d1=%h", p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_word_rw();
        test_byte_mask();
        test_out_of_range();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
